// File: rtl/dlfloat16_issue_ctrl.sv
// Issue/collect sequencer between the FP request channel and the dlfloat16 FPU.
// Optional macro DLF_ISSUE_BACK2BACK_EN lets RESP accept the next request directly.
module dlfloat16_issue_ctrl #(
  parameter int LAT_SHORT = 2,
  parameter int LAT_ARITH = 3,
  parameter int LAT_LONG  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_instr,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  input  logic [31:0] req_op3,
  output logic [31:0] fpu_instr,
  output logic [31:0] fpu_op1,
  output logic [31:0] fpu_op2,
  output logic [31:0] fpu_op3,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic [4:0]  fflags,
  input  logic        fflags_clr,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] lat;
  logic [4:0] f5;
  logic       fused;
  logic       long_op;
  logic       arith_op;
  logic       accept;
  logic       rsp_fire;

  assign f5       = req_instr[31:27];
  assign fused    = req_instr[6:4] == 3'b100;
  assign long_op  = !fused && (f5 == 5'b00011 || f5 == 5'b01011);
  assign arith_op = !fused && (f5 == 5'b00000 || f5 == 5'b00001 ||
                               f5 == 5'b00010);

  always_comb begin
    lat = 4'(LAT_SHORT - 1);
    unique case (1'b1)
      fused:    lat = 4'(LAT_ARITH - 1);
      arith_op: lat = 4'(LAT_ARITH - 1);
      long_op:  lat = 4'(LAT_LONG - 1);
      default:  lat = 4'(LAT_SHORT - 1);
    endcase
  end

`ifdef DLF_ISSUE_BACK2BACK_EN
  assign req_ready = (state == IDLE) || (state == RESP && rsp_ready);
`else
  assign req_ready = (state == IDLE);
`endif

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      fpu_instr  <= '0;
      fpu_op1    <= '0;
      fpu_op2    <= '0;
      fpu_op3    <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      fflags     <= '0;
    end else begin
      // clear-then-set when a clear coincides with delivery
      if (rsp_fire)
        fflags <= (fflags_clr ? 5'b0 : fflags) | rsp_flags;
      else if (fflags_clr)
        fflags <= '0;

      unique case (state)
        EXEC: begin
          if (cnt == 4'd0) begin
            rsp_result <= fpu_result;
            rsp_flags  <= fpu_flags;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: if (rsp_fire) state <= IDLE;
        default: ;
      endcase

      if (accept) begin
        fpu_instr <= req_instr;
        fpu_op1   <= req_op1;
        fpu_op2   <= req_op2;
        fpu_op3   <= req_op3;
        cnt       <= lat;
        state     <= EXEC;
      end
    end
  end

endmodule

// File: doc/dlfloat16_issue_ctrl.md
# dlfloat16_issue_ctrl

Issue/collect sequencer sitting between the core's FP request channel and the `dlfloat16` FPU datapath top.
- Request side: accepts one FP instruction plus operands per valid/ready handshake.
- FPU side: drives the instruction and operands into the FPU and holds them stable for the op class's fixed pipeline latency.
- Collection: samples the FPU result and exception flags, returns them on a valid/ready response channel, and accumulates RISC-V-style sticky `fflags`.
- Ordering: one instruction in flight; strictly in order.

## Interface
Parameters:
- `LAT_SHORT`, default 2: cycles for sign-inject, min/max, compare, int↔float converts.
- `LAT_ARITH`, default 3: cycles for add, sub, mul and fused multiply-add.
- `LAT_LONG`, default 8: cycles for div and sqrt.
- Legal range for all three: 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_instr` in 32: FP instruction word.
- `req_op1`, `req_op2`, `req_op3` in 32 each: operands; DLFloat16 values in [15:0], int32 for fcvt.s.w.
- `fpu_instr` out 32; `fpu_op1`, `fpu_op2`, `fpu_op3` out 32 each: registered FPU inputs.
- `fpu_result` in 32: FPU result.
- `fpu_flags` in 5: FPU exceptions, {invalid, div_by_zero, overflow, underflow, inexact}.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_result` out 32, `rsp_flags` out 5: captured result and flags.
- `fflags` out 5: sticky OR of all delivered `rsp_flags`.
- `fflags_clr` in 1: synchronous clear of `fflags`.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- `req_ready` is 1 only in IDLE (see Configuration for the exception).
- IDLE → EXEC on the request handshake:
  - Register `req_*` into `fpu_*`.
  - Load the down-counter with L−1, where L is the class latency.
- Class decode:
  - `instr[6:2]` = 100xx (fused ops) → ARITH.
  - Otherwise `instr[31:27]` 00011 or 01011 → LONG.
  - Otherwise 00000, 00001, 00010 → ARITH.
  - All other encodings → SHORT.
- EXEC:
  - `fpu_*` are held constant.
  - The counter decrements each cycle.
  - On the cycle the counter is 0: capture `fpu_result` → `rsp_result` and `fpu_flags` → `rsp_flags`, then go to RESP.
- RESP:
  - `rsp_valid` = 1; `rsp_result` and `rsp_flags` are held until `rsp_ready`.
  - On handshake: `fflags |= rsp_flags`, then go to IDLE.
- `fflags_clr`:
  - Zeroes `fflags` in any state.
  - If it coincides with a response handshake, the result is `fflags = rsp_flags` (clear, then set).
- `fpu_*` keep the last accepted values while IDLE; they are not zeroed after an operation.
- Unknown encodings are forwarded unchanged with SHORT latency. The FPU's flags are reported as delivered; no local illegal-instruction detection.

## Timing
- Reset values:
  - State = IDLE; `req_ready` = 1.
  - `rsp_valid` = 0; `busy` = 0.
  - All `fpu_*`, `rsp_result`, `rsp_flags` and `fflags` = 0.
- Reset asserted mid-EXEC or mid-RESP aborts the operation immediately. No response is produced and `fflags` is not updated.
- Latency: request accept edge T → `rsp_valid` high from edge T+L. `fpu_*` are valid from T+1 through at least T+L.
- Throughput without the macro: 1 op per L+2 cycles at best (EXEC L, RESP ≥1, IDLE 1).
- `rsp_ready` held low stalls indefinitely in RESP; outputs stay stable.
- `req_valid` asserted while busy is ignored; the requester must hold it.

## Configuration
- Macro: `DLF_ISSUE_BACK2BACK_EN`.
- Defined:
  - In RESP, `req_ready = rsp_ready`.
  - A simultaneous response handshake and request handshake moves RESP → EXEC directly, loading new `fpu_*` and counter.
  - Best-case throughput becomes 1 op per L+1 cycles.
- Undefined: `req_ready` is high in IDLE only.

## Test plan
- Reset, then fadd (`instr` 0x00000053), op1 = 0x3E00, op2 = 0x3E00 (1.0 + 1.0), FPU returns 0x4000, flags 0:
  - `rsp_valid` rises exactly 3 cycles after accept with `rsp_result` = 0x4000.
  - `fflags` stays 0.
- fdiv (`instr` 0x18000053), op2 = 0x0000, FPU flags 5'b01000:
  - `rsp_valid` after 8 cycles, `rsp_flags` = 01000.
  - `fflags` = 01000 after handshake.
- `rsp_ready` held low 5 cycles with a new `req_valid` asserted:
  - `rsp_result` stable throughout.
  - `req_ready` stays 0; the new request is accepted only after the response handshake.
- `fflags` = 00001, then `fflags_clr` pulsed on the same cycle as a response handshake carrying flags 10000 → `fflags` = 10000.
- `rst_n` dropped 2 cycles into an 8-cycle fsqrt:
  - All outputs return to reset values immediately.
  - No `rsp_valid` after release.
- With `DLF_ISSUE_BACK2BACK_EN`, two fmul ops streamed with `rsp_ready` = 1:
  - Second `rsp_valid` occurs 4 cycles after the first (L + 1).
  - Without the macro the gap is 5 cycles.
